// File: rtl/skdecode_coeff_unpack.sv
// Unpacks t0 (d-bit) or eta lanes into mod-q coefficients: (2^(d-1) - x) mod q or (eta - x) mod q.
// Latency: 2 cycles from input handshake to valid_o. Sustains 1 beat/cycle.
// Backpressure: ready_o = !s2_vld || ready_i; a stall freezes both stages, so no beat is lost or repeated.
//
// Ports:
//   clk, reset_n (async, active-low), zeroize (sync clear, overrides handshakes)
//   mode_i / valid_i / data_i / ready_o : input beat, NUM_LANES lanes of MLDSA_D bits, mode 0=t0 1=eta
//   valid_o / data_o / err_o / last_o / ready_i : output beat, NUM_LANES lanes of REG_SIZE+1 bits (MSB=0)
module skdecode_coeff_unpack #(
  parameter int NUM_LANES = 4,
  parameter int REG_SIZE  = 23,
  parameter int MLDSA_Q   = 8380417,
  parameter int MLDSA_D   = 13,
  parameter int ETA       = 2,
  parameter int COEFFS    = 256
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              zeroize,
  input  logic                              mode_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [NUM_LANES*MLDSA_D-1:0]      data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [NUM_LANES*(REG_SIZE+1)-1:0] data_o,
  output logic                              err_o,
  output logic                              last_o
);

  localparam int BEATS = COEFFS / NUM_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]    LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [REG_SIZE-1:0] T0_OFFSET  = REG_SIZE'(2 ** (MLDSA_D - 1));
  localparam logic [REG_SIZE-1:0] ETA_OFFSET = REG_SIZE'(ETA);
  localparam logic [REG_SIZE-1:0] Q_VAL      = REG_SIZE'(MLDSA_Q);
  localparam logic [3:0]          ETA_MAX    = 4'(2 * ETA);

  // Handshake
  logic advance;
  logic accept;

  // Beat counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage 1: raw difference a + ~b + 1 and its carry (carry=1 means a >= b)
  logic                               s1_vld_q, s1_vld_d;
  logic                               s1_err_q, s1_err_d;
  logic                               s1_last_q, s1_last_d;
  logic [NUM_LANES-1:0]               s1_carry_q, s1_carry_d;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] s1_diff_q, s1_diff_d;

  // Stage 2: final coefficient after conditional +q
  logic                               s2_vld_q, s2_vld_d;
  logic                               s2_err_q, s2_err_d;
  logic                               s2_last_q, s2_last_d;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] s2_coef_q, s2_coef_d;

  // Per-lane combinational working values
  logic [NUM_LANES-1:0][MLDSA_D-1:0]  lane_x;
  logic [NUM_LANES-1:0][3:0]          eta_x;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] sub_a;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] sub_b;
  logic [NUM_LANES-1:0][REG_SIZE:0]   sub_sum;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] corr;
  logic [NUM_LANES-1:0]               lane_err;

  assign advance = !s2_vld_q || ready_i;
  assign accept  = valid_i && advance;
  assign ready_o = advance;

  // Stage-1 adder: a - b as a + ~b + 1; the carry out doubles as "no borrow".
  always_comb begin
    lane_x   = '0;
    eta_x    = '0;
    sub_a    = '0;
    sub_b    = '0;
    sub_sum  = '0;
    lane_err = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_x[k] = data_i[k*MLDSA_D +: MLDSA_D];
      // Only the low 3 (eta=2) or 4 (eta=4) bits carry an eta code; the rest is ignored.
      eta_x[k]  = (ETA == 2) ? {1'b0, lane_x[k][2:0]} : lane_x[k][3:0];
      if (mode_i) begin
        sub_a[k]    = ETA_OFFSET;
        sub_b[k]    = REG_SIZE'(eta_x[k]);
        lane_err[k] = (eta_x[k] > ETA_MAX);
      end else begin
        sub_a[k]    = T0_OFFSET;
        sub_b[k]    = REG_SIZE'(lane_x[k]);
      end
      sub_sum[k] = {1'b0, sub_a[k]} + {1'b0, ~sub_b[k]} + (REG_SIZE+1)'(1);
    end
  end

  // Stage-2 correction: a borrow in stage 1 means the result wrapped, so add q back.
  always_comb begin
    corr = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      corr[k] = s1_carry_q[k] ? '0 : Q_VAL;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    s1_vld_d   = s1_vld_q;
    s1_err_d   = s1_err_q;
    s1_last_d  = s1_last_q;
    s1_carry_d = s1_carry_q;
    s1_diff_d  = s1_diff_q;
    s2_vld_d   = s2_vld_q;
    s2_err_d   = s2_err_q;
    s2_last_d  = s2_last_q;
    s2_coef_d  = s2_coef_q;

    // Both stages move together; a stall at the output holds everything in place.
    if (advance) begin
      s1_vld_d  = valid_i;
      s1_err_d  = valid_i && (|lane_err);
      s1_last_d = accept && (cnt_q == LAST_BEAT);
      for (int k = 0; k < NUM_LANES; k++) begin
        s1_diff_d[k]  = sub_sum[k][REG_SIZE-1:0];
        s1_carry_d[k] = sub_sum[k][REG_SIZE];
        s2_coef_d[k]  = s1_diff_q[k] + corr[k];
      end
      s2_vld_d  = s1_vld_q;
      s2_err_d  = s1_err_q;
      s2_last_d = s1_last_q;
    end

    if (accept) begin
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end

    // Zeroize wins over any handshake in the same cycle.
    if (zeroize) begin
      cnt_d      = '0;
      s1_vld_d   = 1'b0;
      s1_err_d   = 1'b0;
      s1_last_d  = 1'b0;
      s1_carry_d = '0;
      s1_diff_d  = '0;
      s2_vld_d   = 1'b0;
      s2_err_d   = 1'b0;
      s2_last_d  = 1'b0;
      s2_coef_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_carry_q <= '0;
      s1_diff_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_coef_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_err_q   <= s1_err_d;
      s1_last_q  <= s1_last_d;
      s1_carry_q <= s1_carry_d;
      s1_diff_q  <= s1_diff_d;
      s2_vld_q   <= s2_vld_d;
      s2_err_q   <= s2_err_d;
      s2_last_q  <= s2_last_d;
      s2_coef_q  <= s2_coef_d;
    end
  end

  // Outputs are forced to zero whenever no beat is presented.
  always_comb begin
    data_o = '0;
    if (s2_vld_q) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        data_o[k*(REG_SIZE+1) +: REG_SIZE+1] = {1'b0, s2_coef_q[k]};
      end
    end
  end

  assign valid_o = s2_vld_q;
  assign err_o   = s2_vld_q && s2_err_q;
  assign last_o  = s2_vld_q && s2_last_q;

endmodule

// File: tb/tb_skdecode_coeff_unpack.sv
// Bench for skdecode_coeff_unpack at default parameters (4 lanes, q=8380417, d=13, eta=2, 64 beats/poly).
// Latency: outputs checked 2 cycles after presentation; scoreboard checks every output cycle.
// Backpressure: random and directed ready_i stalls, with held-output checks against the scoreboard front.
module tb_skdecode_coeff_unpack;

  localparam int Q      = 8380417;
  localparam int ETA_TB = 2;
  localparam int BEATS  = 64;

  typedef struct packed {
    logic             mode;
    logic [3:0][12:0] x;
    logic [3:0][22:0] want;
    logic             err;
  } vec_t;

  typedef struct packed {
    logic [3:0][22:0] d;
    logic             err;
    logic             last;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        zeroize;
  logic        mode_i;
  logic        valid_i;
  logic        ready_o;
  logic [51:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [95:0] data_o;
  logic        err_o;
  logic        last_o;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   out_hs = 0;
  int   last_cnt = 0;
  int   model_cnt = 0;
  bit   done;
  exp_t exp_q[$];
  vec_t vecs[8];

  skdecode_coeff_unpack dut (
    .clk     (clk),
    .reset_n (reset_n),
    .zeroize (zeroize),
    .mode_i  (mode_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .err_o   (err_o),
    .last_o  (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
  endtask

  // Reference: plain modular arithmetic straight from the field definitions.
  function automatic exp_t model(input logic mode, input logic [51:0] din, input logic last);
    exp_t e;
    int   x, v;
    e = '0;
    e.last = last;
    for (int k = 0; k < 4; k++) begin
      x = int'(din[k*13 +: 13]);
      if (mode) begin
        x = x % 8;
        if (x > 2 * ETA_TB) e.err = 1'b1;
        v = ETA_TB - x;
      end else begin
        v = 4096 - x;
      end
      if (v < 0) v = v + Q;
      e.d[k] = v[22:0];
    end
    return e;
  endfunction

  function automatic logic [95:0] pack(input logic [3:0][22:0] d);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*24 +: 24] = {1'b0, d[k]};
    return r;
  endfunction

  function automatic vec_t mkvec(input logic m, input int x0, input int x1, input int x2, input int x3,
                                 input int w0, input int w1, input int w2, input int w3, input logic e);
    vec_t v;
    v.mode = m;
    v.x    = {13'(x3), 13'(x2), 13'(x1), 13'(x0)};
    v.want = {23'(w3), 23'(w2), 23'(w1), 23'(w0)};
    v.err  = e;
    return v;
  endfunction

  // Scoreboard: sampled mid-cycle, where all handshake signals are settled.
  always @(negedge clk) begin
    if (!reset_n || zeroize) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 96'(valid_o), 96'(0));
        end else begin
          chk("out_data", data_o, pack(exp_q[0].d));
          chk("out_err", 96'(err_o), 96'(exp_q[0].err));
          chk("out_last", 96'(last_o), 96'(exp_q[0].last));
          if (ready_i) begin
            void'(exp_q.pop_front());
            out_hs++;
            if (last_o) last_cnt++;
          end
        end
      end else begin
        chk("idle_data_zero", data_o, 96'(0));
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model(mode_i, data_i, model_cnt == BEATS - 1));
        model_cnt = (model_cnt + 1) % BEATS;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic m, input logic [51:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    mode_i = m;
    data_i = d;
    valid_i = 1'b1;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 96'(acc), 96'(1));
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_beat(1'($urandom_range(0, 1)), 52'({$urandom(), $urandom()}));
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cs, hs0, l0;
    reset_n = 1'b0; zeroize = 1'b0; valid_i = 1'b0; ready_i = 1'b1; mode_i = 1'b0; data_i = '0;

    vecs[0] = mkvec(0, 0, 4096, 8191, 1,    4096, 0, 8376322, 4095, 0);
    vecs[1] = mkvec(1, 0, 2, 4, 5,          2, 0, 8380415, 8380414, 1);
    vecs[2] = mkvec(1, 0, 2, 4, 3,          2, 0, 8380415, 8380416, 0);
    vecs[3] = mkvec(0, 0, 0, 0, 0,          4096, 4096, 4096, 4096, 0);
    vecs[4] = mkvec(1, 0, 0, 0, 0,          2, 2, 2, 2, 0);
    vecs[5] = mkvec(1, 8, 8191, 4106, 1,    2, 8380412, 0, 1, 1);
    vecs[6] = mkvec(0, 8191, 4097, 4095, 2, 8376322, 8380416, 1, 4094, 0);
    vecs[7] = mkvec(0, 4096, 4096, 4096, 4096, 0, 0, 0, 0, 0);

    #3;
    chk("rst_valid_o", 96'(valid_o), 96'(0));
    chk("rst_data_o", data_o, 96'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_ready_o", 96'(ready_o), 96'(1));
    chk("rst_err_o", 96'(err_o), 96'(0));
    chk("rst_last_o", 96'(last_o), 96'(0));

    // Directed vectors, presented back-to-back; vector c-1 is visible after the tick of iteration c.
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        mode_i = vecs[c].mode;
        data_i = vecs[c].x;
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      if (c == 0) chk("latency_not_early", 96'(valid_o), 96'(0));
      else begin
        chk("vec_valid", 96'(valid_o), 96'(1));
        chk("vec_data", data_o, pack(vecs[c-1].want));
        chk("vec_err", 96'(err_o), 96'(vecs[c-1].err));
      end
    end

    zeroize = 1'b1; tick(); zeroize = 1'b0;
    chk("zeroize_idle", 96'(valid_o), 96'(0));

    // Full polynomial at full rate.
    cs = cyc; hs0 = out_hs; l0 = last_cnt;
    send_random(BEATS);
    chk("stream_cycles", 96'(cyc - cs), 96'(BEATS));
    repeat (2) tick();
    chk("stream_outputs", 96'(out_hs - hs0), 96'(BEATS));
    chk("stream_last_count", 96'(last_cnt - l0), 96'(1));
    chk("stream_drained", 96'(exp_q.size()), 96'(0));

    // Second polynomial with random backpressure; counter must have wrapped to 0.
    l0 = last_cnt; done = 1'b0;
    fork
      begin send_random(BEATS); done = 1'b1; end
      begin
        while (!done) begin ready_i = ($urandom_range(0, 3) != 0); tick(); end
        ready_i = 1'b1;
      end
    join
    repeat (4) tick();
    chk("bp_last_count", 96'(last_cnt - l0), 96'(1));
    chk("bp_drained", 96'(exp_q.size()), 96'(0));

    // Five-cycle stall with valid_i held.
    hs0 = out_hs;
    fork
      send_random(8);
      begin
        ready_i = 1'b0;
        repeat (3) tick();
        chk("stall_ready_o", 96'(ready_o), 96'(0));
        chk("stall_valid_o", 96'(valid_o), 96'(1));
        repeat (2) tick();
        ready_i = 1'b1;
      end
    join
    repeat (3) tick();
    chk("stall_outputs", 96'(out_hs - hs0), 96'(8));
    chk("stall_drained", 96'(exp_q.size()), 96'(0));

    // Zeroize at beat 10 with beats 8 and 9 in flight.
    zeroize = 1'b1; tick(); zeroize = 1'b0;
    send_random(10);
    mode_i = 1'b0; data_i = '0; valid_i = 1'b1; zeroize = 1'b1;
    tick();
    zeroize = 1'b0; valid_i = 1'b0;
    chk("zeroize_flush_valid", 96'(valid_o), 96'(0));
    chk("zeroize_ready", 96'(ready_o), 96'(1));
    l0 = last_cnt;
    send_random(BEATS);
    repeat (3) tick();
    chk("post_zeroize_last", 96'(last_cnt - l0), 96'(1));
    chk("post_zeroize_drained", 96'(exp_q.size()), 96'(0));

    // Asynchronous reset mid-polynomial.
    send_random(20);
    reset_n = 1'b0;
    #2;
    chk("async_reset_valid", 96'(valid_o), 96'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    l0 = last_cnt;
    send_random(BEATS);
    repeat (3) tick();
    chk("post_reset_last", 96'(last_cnt - l0), 96'(1));
    chk("post_reset_drained", 96'(exp_q.size()), 96'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/skdecode_coeff_unpack.md
SKDECODE_COEFF_UNPACK -- requirements
Module: skdecode_coeff_unpack

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, meaning coefficients processed per beat (1, 2, 4 or 8).
REQ-002 SHALL have parameter REG_SIZE, default 23, meaning the modular arithmetic width.
REQ-003 SHALL have parameter MLDSA_Q, default 8380417, meaning the modulus q.
REQ-004 SHALL have parameter MLDSA_D, default 13, meaning the t0 field width d.
REQ-005 SHALL have parameter ETA, default 2, meaning the eta bound (2 or 4).
REQ-006 SHALL have parameter COEFFS, default 256, meaning coefficients per polynomial.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port zeroize, input, 1 bit: synchronous clear.
REQ-010 SHALL have port mode_i, input, 1 bit: 0 = t0 unpack, 1 = eta unpack; sampled with each accepted beat.
REQ-011 SHALL have port valid_i, input, 1 bit: input beat valid.
REQ-012 SHALL have port ready_o, output, 1 bit: block can accept a beat.
REQ-013 SHALL have port data_i, input, NUM_LANES*MLDSA_D bits: lane k = bits [k*D +: D].
REQ-014 SHALL have port valid_o, output, 1 bit: output beat valid.
REQ-015 SHALL have port ready_i, input, 1 bit: downstream accepts.
REQ-016 SHALL have port data_o, output, NUM_LANES*(REG_SIZE+1) bits: lane k coefficient with MSB = 0.
REQ-017 SHALL have port err_o, output, 1 bit: output beat contains an invalid eta encoding.
REQ-018 SHALL have port last_o, output, 1 bit: output beat is the final beat of a polynomial.

Function
REQ-019 SHALL, in t0 mode, output per lane (2^(D-1) - x) mod q, with x = lane[D-1:0], range [0, q-1].
REQ-020 SHALL, in eta mode, take x = lane[2:0] (ETA=2) or lane[3:0] (ETA=4), ignore the upper lane bits, and output (ETA - x) mod q.
REQ-021 SHALL compute the subtraction with two REG_SIZE adders per lane:
- stage 1: a + ~b + 1, carry registered;
- stage 2: conditional add of q selected by the stage-1 carry.
- No divider and no multiplier.
REQ-022 SHALL, in eta mode, flag a lane invalid when x > 2*ETA; err_o = OR over lanes for that beat, and the invalid lane data still SHALL be computed per REQ-020.
REQ-023 SHALL be a 2-stage pipeline: an accepted beat appears on valid_o exactly 2 cycles later when ready_i stays high.
REQ-024 SHALL transfer a beat on an interface only when valid and ready are both high on the same clk edge.
REQ-025 SHALL drive ready_o = !(stage-2 valid) || ready_i, so that a stall freezes both stages with no beat lost or duplicated.
REQ-026 SHALL sustain 1 beat/cycle throughput with ready_i held high.
REQ-027 SHALL hold data_o, err_o and last_o stable while valid_o=1 and ready_i=0.
REQ-028 SHALL keep a beat counter of width clog2(COEFFS/NUM_LANES):
- increments on each input handshake;
- last_o follows the beat counted at COEFFS/NUM_LANES-1 through the pipeline;
- the counter wraps to 0 after that beat.
REQ-029 SHALL carry mode_i with its beat, so that a mode change between consecutive beats produces correct results for both beats.
REQ-030 SHALL drive data_o to 0 when valid_o=0.

Reset
REQ-031 SHALL, on reset_n low, asynchronously clear all pipeline registers, valid flags and the beat counter, giving valid_o=0, data_o=0, err_o=0, last_o=0 and ready_o=1 after release.
REQ-032 SHALL, on zeroize high, synchronously apply the same clear on the next clk edge, overriding any handshake in that cycle.
REQ-033 SHALL, on reset or zeroize mid-polynomial, discard the in-flight beats and restart counting from beat 0.

Verification
REQ-034 SHALL cover t0 mode, NUM_LANES=4, lanes x = {0, 4096, 8191, 1} -> data_o lanes {4096, 0, 8376322, 4095} two cycles later, err_o=0.
REQ-035 SHALL cover eta mode, ETA=2, lanes x = {0, 2, 4, 5} -> lanes {2, 0, 8380415, 8380414} and err_o=1; with 5 replaced by 3 -> lane 3 = 8380416 and err_o=0.
REQ-036 SHALL cover streaming 64 beats with ready_i=1 -> 64 output beats on consecutive cycles, last_o=1 only on beat 63, and the counter back at 0.
REQ-037 SHALL cover ready_i=0 for 5 cycles while valid_i=1 -> ready_o=0 after the pipeline fills, outputs held, and after release all beats delivered in order with none lost.
REQ-038 SHALL cover zeroize asserted at beat 10 with 2 beats in flight -> valid_o=0 next cycle, and the next polynomial's last_o at its own beat 63.
REQ-039 SHALL cover alternating mode_i per beat (t0 x=0, eta x=0) -> outputs 4096 then 2.
